// File: rtl/tmec_decode_serial_ctrl_pkg.sv
// Shared definitions for the serial Berlekamp sequencer.
//   state_e : FSM encoding (IDLE -> LOAD -> CALC -> FIN -> IDLE)
//   cnt_w   : counter width helper, at least one bit even for a count of 1
package tmec_decode_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmec_decode_serial_ctrl.sv
// Sequencer for the serial inversion-based Berlekamp datapath of the
// t-error BCH decoder. A start pulse (honoured only while idle) runs one
// LOAD cycle, then T iterations of M bit-serial CALC cycles, then one FIN
// cycle that pulses done and latches the error-locator degree L.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   start      in   pulse: syndromes valid
//   drnzero    in   datapath discrepancy != 0
//   busy       out  LOAD and CALC
//   synpe      out  syndrome / c1 parallel load (LOAD)
//   cbBeg      out  clears cN, seeds b registers (LOAD)
//   snce, cce  out  syndrome / cN shift enables (every CALC cycle)
//   msmpe      out  serial standard multiplier start (first bit)
//   dringPe    out  serial mixed multiplier start (first bit)
//   caLast     out  last bit of the current iteration
//   c0first    out  iteration 0 marker
//   bsel       out  B-update select, L update taken
//   done       out  one-cycle pulse, locator valid
//   err_count  out  final L saturated at T+1
//   too_many   out  L > T at done
module tmec_decode_serial_ctrl
  import tmec_decode_serial_ctrl_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   drnzero,
  output logic                   busy,
  output logic                   synpe,
  output logic                   cbBeg,
  output logic                   snce,
  output logic                   cce,
  output logic                   msmpe,
  output logic                   dringPe,
  output logic                   caLast,
  output logic                   c0first,
  output logic                   bsel,
  output logic                   done,
  output logic [$clog2(T+2)-1:0] err_count,
  output logic                   too_many
);

  localparam int BW = cnt_w(M);
  localparam int IW = cnt_w(T);
  localparam int LW = $clog2(2*T+2);
  localparam int EW = $clog2(T+2);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [LW-1:0]   l_q, l_d;
  logic [EW-1:0]   err_q, err_d;
  logic            tm_q, tm_d;

  // Clamp the locator degree to T+1 so it fits the err_count port.
  function automatic logic [EW-1:0] sat_err(input logic [LW-1:0] l);
    logic [EW-1:0] r;
    if (l > LW'(T+1)) r = EW'(T+1);
    else              r = EW'(l);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      iter_q  <= '0;
      l_q     <= '0;
      err_q   <= '0;
      tm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      iter_q  <= iter_d;
      l_q     <= l_d;
      err_q   <= err_d;
      tm_q    <= tm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    iter_d  = iter_q;
    l_d     = l_q;
    err_d   = err_q;
    tm_d    = tm_q;
    busy    = 1'b0;
    synpe   = 1'b0;
    cbBeg   = 1'b0;
    snce    = 1'b0;
    cce     = 1'b0;
    msmpe   = 1'b0;
    dringPe = 1'b0;
    caLast  = 1'b0;
    c0first = 1'b0;
    bsel    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        busy    = 1'b1;
        synpe   = 1'b1;
        cbBeg   = 1'b1;
        // L and iter_cnt are being cleared this cycle, so the L <= iter
        // term is trivially true; do not look at the stale registers.
        bsel    = drnzero;
        l_d     = '0;
        iter_d  = '0;
        bit_d   = '0;
        err_d   = '0;
        tm_d    = 1'b0;
        state_d = ST_CALC;
      end

      ST_CALC: begin
        busy    = 1'b1;
        snce    = 1'b1;
        cce     = 1'b1;
        msmpe   = (bit_q == '0);
        dringPe = (bit_q == '0);
        caLast  = (bit_q == BW'(M-1));
        c0first = (iter_q == '0);
        bsel    = drnzero && (l_q <= LW'(iter_q));
        if (caLast) begin
          // Berlekamp length update: L' = 2r + 1 - L
          if (bsel) l_d = (LW'(iter_q) << 1) + LW'(1) - l_q;
          bit_d = '0;
          if (iter_q == IW'(T-1)) state_d = ST_FIN;
          else                    iter_d  = iter_q + IW'(1);
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        err_d   = sat_err(l_q);
        tm_d    = (l_q > LW'(T));
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign err_count = err_q;
  assign too_many  = tm_q;

endmodule

// File: tb/tb_tmec_decode_serial_ctrl.sv
module tb_tmec_decode_serial_ctrl;

  localparam int M = 4;
  localparam int T = 3;
  localparam int EW = $clog2(T+2);
  localparam int LAST = 2 + T*M;

  logic clk = 1'b0;
  logic reset, start, drnzero;
  logic busy, synpe, cbBeg, snce, cce, msmpe, dringPe, caLast, c0first, bsel, done;
  logic [EW-1:0] err_count;
  logic too_many;
  logic [10:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tmec_decode_serial_ctrl #(.M(M), .T(T)) dut (
    .clk(clk), .reset(reset), .start(start), .drnzero(drnzero),
    .busy(busy), .synpe(synpe), .cbBeg(cbBeg), .snce(snce), .cce(cce),
    .msmpe(msmpe), .dringPe(dringPe), .caLast(caLast), .c0first(c0first),
    .bsel(bsel), .done(done), .err_count(err_count), .too_many(too_many)
  );

  assign outs = {busy, synpe, cbBeg, snce, cce, msmpe, dringPe, caLast, c0first, bsel, done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One decode. d[k] is the discrepancy flag presented at iteration k's last
  // bit; other cycles get random drnzero. abort_at>0 asserts reset in that
  // cycle. extra_starts pulses start in cycle 3 and in the done cycle.
  task automatic run_op(input logic [T-1:0] d, input int abort_at, input bit extra_starts);
    int L, pos, bt, it, exp_err;
    bit calc;
    logic drz, e_bsel;
    logic [10:0] exp;
    L = 0;
    @(negedge clk);
    start   = 1'b1;
    drnzero = 1'($urandom_range(1, 0));
    for (int c = 1; c <= LAST; c++) begin
      @(posedge clk); #1;
      start = extra_starts && (c == 3 || c == LAST);
      calc  = (c >= 2) && (c <= LAST - 1);
      pos   = c - 2;
      bt    = calc ? pos % M : 0;
      it    = calc ? pos / M : 0;
      if (calc && bt == M-1) drz = d[it];
      else                   drz = 1'($urandom_range(1, 0));
      drnzero = drz;
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("abort strobes c=%0d", c), 32'(outs), 32'd0);
        chk("abort err_count", 32'(err_count), 32'd0);
        chk("abort too_many", 32'(too_many), 32'd0);
        #1;
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      if (c == 1)    e_bsel = drz;
      else if (calc) e_bsel = drz && (L <= it);
      else           e_bsel = 1'b0;
      exp = {(c < LAST), (c == 1), (c == 1), calc, calc,
             calc && bt == 0, calc && bt == 0, calc && bt == M-1,
             calc && it == 0, e_bsel, (c == LAST)};
      chk($sformatf("strobes c=%0d", c), 32'(outs), 32'(exp));
      if (calc && bt == M-1 && e_bsel) L = 2*it + 1 - L;
    end
    // Edge after done: a start pulse held here must be ignored.
    @(posedge clk); #1;
    start = 1'b0;
    drnzero = 1'($urandom_range(1, 0));
    exp_err = (L > T+1) ? T+1 : L;
    @(negedge clk);
    chk("idle strobes after done", 32'(outs), 32'd0);
    chk($sformatf("err_count d=%b", d), 32'(err_count), 32'(exp_err));
    chk($sformatf("too_many d=%b", d), 32'(too_many), 32'(L > T));
    @(negedge clk);
    chk("still idle", 32'(outs), 32'd0);
    chk("err_count held", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drnzero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset strobes", 32'(outs), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset too_many", 32'(too_many), 32'd0);
    reset = 1'b0;

    run_op(3'b000, 0, 1'b0);   // no discrepancies: L=0
    run_op(3'b111, 0, 1'b0);   // L 0->1->2->3
    run_op(3'b001, 0, 1'b0);   // L=1
    run_op(3'b101, 0, 1'b0);   // L=1 then 4: too_many
    run_op(T'($urandom), 0, 1'b1);
    run_op(T'($urandom), 7, 1'b0);
    run_op(3'b111, 0, 1'b0);   // clean run after abort
    for (int k = 0; k < 6; k++) run_op(T'($urandom), 0, 1'(k % 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
